// File: rtl/io_bus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_responder_pkg
// Description : Shared constants and types for the io_bus_responder block.
//               This covers the register map, the STATUS bit positions and
//               the transaction FSM states.
//               Optional feature macro: IO_BUS_RESPONDER_IRQ_EN
// Revision    : 1.0 - initial release
// ============================================================================
package io_bus_responder_pkg;

   // Register select decode (io_addr)
   localparam logic [1:0] C_ADDR_DATA   = 2'd0;
   localparam logic [1:0] C_ADDR_STATUS = 2'd1;
   localparam logic [1:0] C_ADDR_COUNT  = 2'd2;
   localparam logic [1:0] C_ADDR_RSVD   = 2'd3;

   // STATUS register bit positions
   localparam int C_STAT_NOT_EMPTY = 0;
   localparam int C_STAT_FULL      = 1;
   localparam int C_STAT_IRQ_EN    = 2;

   // Transaction FSM: IDLE -> ACCESS (rdy high) -> DONE (wait for strobes low)
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/io_bus_responder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_fifo
// Description : Synchronous FIFO with a combinational head output. Pushes are
//               ignored when full and pops are ignored when empty. Pointers
//               wrap modulo DEPTH, which must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module io_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int             AW      = $clog2(DEPTH);
   localparam logic [AW:0]    C_DEPTH = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q,  count_d;
   logic             w_push, w_pop;

   assign full   = (count_q == C_DEPTH);
   assign empty  = (count_q == '0);
   assign count  = count_q;
   assign head   = mem_q[rd_ptr_q];

   // Qualified requests so an overflow or underflow can never corrupt state
   assign w_push = push & ~full;
   assign w_pop  = pop  & ~empty;

   // Pointer and occupancy next-state; simultaneous push and pop keeps count
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written so it has no reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/io_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_responder
// Description : Memory-mapped I/O responder on a bidirectional CPU data bus.
//               CPU writes to DATA go to out_port. Peripheral words are
//               buffered in an input FIFO and are read back through DATA.
//               Reads are answered with a registered, single-cycle rdy.
//               Optional feature macro: IO_BUS_RESPONDER_IRQ_EN adds the
//               irq_en register, STATUS bit2 and the data-available irq.
// Revision    : 1.0 - initial release
// ============================================================================
module io_bus_responder
   import io_bus_responder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       io_addr,
   input  logic             io_rd,
   input  logic             io_wr,
   inout  wire  [WIDTH-1:0] bus,
   output logic             rdy,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_t           state_q, state_d;
   logic             is_rd_q, is_rd_d;
   logic             pop_pend_q, pop_pend_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [WIDTH-1:0] out_port_q, out_port_d;

   logic             w_start;
   logic             w_bus_oe;
   logic             w_fifo_push;
   logic             w_fifo_pop;
   logic             w_full;
   logic             w_empty;
   logic [WIDTH-1:0] w_head;
   logic [CW-1:0]    w_count;
   logic [WIDTH-1:0] w_status;
   logic [WIDTH-1:0] w_rd_word;
   logic             w_irq_en;

   // ------------------------------------------------------------------------
   // Input FIFO
   // ------------------------------------------------------------------------
   assign in_ready    = ~w_full;
   assign w_fifo_push = in_valid & ~w_full;

   io_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (w_fifo_push),
      .pop     (w_fifo_pop),
      .wdata   (in_data),
      .head    (w_head),
      .full    (w_full),
      .empty   (w_empty),
      .count   (w_count)
   );

   // A transaction starts only when exactly one strobe is high in IDLE
   assign w_start = (state_q == ST_IDLE) & (io_rd ^ io_wr);

   // ------------------------------------------------------------------------
   // Transaction FSM
   // ------------------------------------------------------------------------

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: DONE holds until both strobes drop so a held strobe never repeats
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (w_start)           state_d = ST_ACCESS;
         ST_ACCESS:                        state_d = ST_DONE;
         ST_DONE:   if (!io_rd && !io_wr)  state_d = ST_IDLE;
         default:                          state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: rdy and bus drive exist only in ACCESS; the pop commits on leaving it
   always_comb begin
      rdy        = 1'b0;
      w_bus_oe   = 1'b0;
      w_fifo_pop = 1'b0;
      if (state_q == ST_ACCESS) begin
         rdy        = 1'b1;
         w_bus_oe   = is_rd_q;
         w_fifo_pop = pop_pend_q;
      end
   end

   // ------------------------------------------------------------------------
   // Register file and read mux
   // ------------------------------------------------------------------------

   // STATUS word assembled from the FIFO flags and the interrupt enable
   always_comb begin
      w_status                   = '0;
      w_status[C_STAT_NOT_EMPTY] = ~w_empty;
      w_status[C_STAT_FULL]      = w_full;
      w_status[C_STAT_IRQ_EN]    = w_irq_en;
   end

   // Read word selection by address; empty DATA and reserved read as zero
   always_comb begin
      w_rd_word = '0;
      case (io_addr)
         C_ADDR_DATA:   if (!w_empty) w_rd_word = w_head;
         C_ADDR_STATUS: w_rd_word = w_status;
         C_ADDR_COUNT:  w_rd_word[CW-1:0] = w_count;
         default:       w_rd_word = '0;
      endcase
   end

   // Capture the read word, the pop decision and write data at the start edge
   always_comb begin
      is_rd_d    = is_rd_q;
      pop_pend_d = pop_pend_q;
      rdata_d    = rdata_q;
      out_port_d = out_port_q;
      if (w_start) begin
         is_rd_d    = io_rd;
         // Pop only what was actually returned: the FIFO must be non-empty now
         pop_pend_d = io_rd & (io_addr == C_ADDR_DATA) & ~w_empty;
         if (io_rd) begin
            rdata_d = w_rd_word;
         end
         if (io_wr && (io_addr == C_ADDR_DATA)) begin
            out_port_d = bus;
         end
      end else if (state_q == ST_ACCESS) begin
         pop_pend_d = 1'b0;
      end
   end

   // Transaction datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         is_rd_q    <= 1'b0;
         pop_pend_q <= 1'b0;
         rdata_q    <= '0;
         out_port_q <= '0;
      end else begin
         is_rd_q    <= is_rd_d;
         pop_pend_q <= pop_pend_d;
         rdata_q    <= rdata_d;
         out_port_q <= out_port_d;
      end
   end

   assign out_port = out_port_q;

   // ------------------------------------------------------------------------
   // Optional data-available interrupt
   // ------------------------------------------------------------------------
`ifdef IO_BUS_RESPONDER_IRQ_EN
   logic irq_en_q, irq_en_d;
   logic irq_q, irq_d;

   // Enable is written through STATUS bit2; irq is registered, lagging the FIFO by one cycle
   always_comb begin
      irq_en_d = irq_en_q;
      if (w_start && io_wr && (io_addr == C_ADDR_STATUS)) begin
         irq_en_d = bus[C_STAT_IRQ_EN];
      end
      irq_d = irq_en_q & ~w_empty;
   end

   // Interrupt enable and interrupt registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   assign w_irq_en = irq_en_q;
   assign irq      = irq_q;
`else
   assign w_irq_en = 1'b0;
   assign irq      = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Tristate bus driver: only a read in ACCESS drives the shared bus
   // ------------------------------------------------------------------------
   assign bus = w_bus_oe ? rdata_q : {WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_io_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_bus_responder
// Description : Self-checking bench for io_bus_responder. It uses directed
//               scenarios plus randomized traffic against a queue-based model.
//               Interrupt checks are active when IO_BUS_RESPONDER_IRQ_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bus_responder;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [1:0]       io_addr = 2'd0;
   logic             io_rd = 1'b0;
   logic             io_wr = 1'b0;
   logic             rdy;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] out_port;
   logic             irq;
   wire  [WIDTH-1:0] bus;
   logic             tb_bus_en = 1'b0;
   logic [WIDTH-1:0] tb_bus = '0;

   assign bus = tb_bus_en ? tb_bus : {WIDTH{1'bz}};

   always #5 clk = ~clk;

   io_bus_responder #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .io_addr  (io_addr),
      .io_rd    (io_rd),
      .io_wr    (io_wr),
      .bus      (bus),
      .rdy      (rdy),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_port (out_port),
      .irq      (irq)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [WIDTH-1:0] m_q[$];
   logic [WIDTH-1:0] m_out_port = '0;
   logic             m_irq_en = 1'b0;
   logic             m_irq = 1'b0;
   logic             m_pop_due = 1'b0;
   logic             m_rand = 1'b0;

   function automatic logic [WIDTH-1:0] model_read(input logic [1:0] addr);
      logic [WIDTH-1:0] v;
      v = '0;
      case (addr)
         2'd0:    if (m_q.size() != 0) v = m_q[0];
         2'd1:    v = {13'd0, m_irq_en, (m_q.size() == DEPTH), (m_q.size() != 0)};
         2'd2:    v = WIDTH'(m_q.size());
         default: v = '0;
      endcase
      return v;
   endfunction

   // One clock edge: inputs already applied; the model advances with the edge
   task automatic tick();
      logic             do_push;
      logic             irq_next;
      logic [WIDTH-1:0] din;
      if (m_rand) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_data  = WIDTH'($urandom);
      end
      din      = in_data;
      do_push  = in_valid && (m_q.size() < DEPTH);
      irq_next = m_irq_en && (m_q.size() != 0);
      @(posedge clk);
      if (m_pop_due && (m_q.size() != 0)) void'(m_q.pop_front());
      m_pop_due = 1'b0;
      if (do_push) m_q.push_back(din);
      m_irq = irq_next;
      #1;
   endtask

   task automatic push_word(input logic [WIDTH-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_read(input logic [1:0] addr, output logic [WIDTH-1:0] data,
                          output logic [WIDTH-1:0] exp);
      logic pop_flag;
      io_addr  = addr;
      io_rd    = 1'b1;
      exp      = model_read(addr);
      pop_flag = (addr == 2'd0) && (m_q.size() != 0);
      tick();
      n_checks++;
      if (rdy !== 1'b1) begin
         n_errors++;
         $display("FAIL rd_rdy_rise: rdy=%b expected 1", rdy);
      end
      data      = bus;
      m_pop_due = pop_flag;
      io_rd     = 1'b0;
      tick();
      n_checks++;
      if (rdy !== 1'b0) begin
         n_errors++;
         $display("FAIL rd_rdy_pulse: rdy=%b expected 0", rdy);
      end
      tick();
   endtask

   task automatic do_write(input logic [1:0] addr, input logic [WIDTH-1:0] data);
      io_addr   = addr;
      io_wr     = 1'b1;
      tb_bus_en = 1'b1;
      tb_bus    = data;
      tick();
      n_checks++;
      if (rdy !== 1'b1) begin
         n_errors++;
         $display("FAIL wr_rdy_rise: rdy=%b expected 1", rdy);
      end
      if (addr == 2'd0) m_out_port = data;
`ifdef IO_BUS_RESPONDER_IRQ_EN
      if (addr == 2'd1) m_irq_en = data[2];
`endif
      io_wr     = 1'b0;
      tb_bus_en = 1'b0;
      tick();
      n_checks++;
      if (rdy !== 1'b0) begin
         n_errors++;
         $display("FAIL wr_rdy_pulse: rdy=%b expected 0", rdy);
      end
      tick();
   endtask

   task automatic test_reset();
      logic [WIDTH-1:0] d, e;
      n_checks++;
      if (rdy !== 1'b0 || out_port !== '0 || in_ready !== 1'b1 || irq !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_por: rdy=%b out_port=%h in_ready=%b irq=%b expected 0/0000/1/0",
                  rdy, out_port, in_ready, irq);
      end
      do_read(2'd2, d, e);
      n_checks++;
      if (d !== 16'd0) begin
         n_errors++;
         $display("FAIL reset_count: got %h expected 0000", d);
      end
      // Build up non-reset state, then reset in the middle of a read
      do_write(2'd0, 16'h1234);
      push_word(16'hBEEF);
      io_addr = 2'd0;
      io_rd   = 1'b1;
      @(posedge clk);
      #3;
      n_checks++;
      if (rdy !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_pre_rdy: rdy=%b expected 1", rdy);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (rdy !== 1'b0 || out_port !== '0 || in_ready !== 1'b1 || irq !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_async: rdy=%b out_port=%h in_ready=%b irq=%b expected 0/0000/1/0",
                  rdy, out_port, in_ready, irq);
      end
      tb_bus_en = 1'b1;
      tb_bus    = '0;
      #1;
      n_checks++;
      if (bus !== 16'h0000) begin
         n_errors++;
         $display("FAIL reset_bus_release: bus=%h expected 0000", bus);
      end
      tb_bus_en = 1'b0;
      io_rd     = 1'b0;
      m_q.delete();
      m_out_port = '0;
      m_irq_en   = 1'b0;
      m_irq      = 1'b0;
      m_pop_due  = 1'b0;
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      tick();
      do_read(2'd2, d, e);
      n_checks++;
      if (d !== 16'd0) begin
         n_errors++;
         $display("FAIL reset_mid_count: got %h expected 0000", d);
      end
   endtask

   task automatic test_write_data();
      io_addr   = 2'd0;
      io_wr     = 1'b1;
      tb_bus_en = 1'b1;
      tb_bus    = 16'hA5C3;
      n_checks++;
      if (rdy !== 1'b0) begin
         n_errors++;
         $display("FAIL wr_rdy_early: rdy=%b expected 0", rdy);
      end
      tick();
      m_out_port = 16'hA5C3;
      n_checks++;
      if (rdy !== 1'b1 || out_port !== 16'hA5C3) begin
         n_errors++;
         $display("FAIL wr_data: rdy=%b out_port=%h expected 1/a5c3", rdy, out_port);
      end
      tb_bus = 16'h5A5A;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (rdy !== 1'b0) begin
            n_errors++;
            $display("FAIL wr_done_hold: cycle %0d rdy=%b expected 0", i, rdy);
         end
      end
      n_checks++;
      if (out_port !== 16'hA5C3) begin
         n_errors++;
         $display("FAIL wr_no_repeat: out_port=%h expected a5c3", out_port);
      end
      io_wr     = 1'b0;
      tb_bus_en = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_fill_drain();
      logic [WIDTH-1:0] pat [4];
      logic [WIDTH-1:0] d, e;
      pat[0] = 16'h0011; pat[1] = 16'h0022; pat[2] = 16'h0033; pat[3] = 16'h0044;
      for (int i = 0; i < 4; i++) push_word(pat[i]);
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL fill_in_ready: in_ready=%b expected 0", in_ready);
      end
      push_word(16'h0055);
      do_read(2'd1, d, e);
      n_checks++;
      if (d !== 16'h0003) begin
         n_errors++;
         $display("FAIL fill_status: got %h expected 0003", d);
      end
      do_read(2'd2, d, e);
      n_checks++;
      if (d !== 16'h0004) begin
         n_errors++;
         $display("FAIL fill_count: got %h expected 0004", d);
      end
      for (int i = 0; i < 4; i++) begin
         do_read(2'd0, d, e);
         n_checks++;
         if (d !== pat[i]) begin
            n_errors++;
            $display("FAIL drain_data: read %0d got %h expected %h", i, d, pat[i]);
         end
      end
      do_read(2'd0, d, e);
      n_checks++;
      if (d !== 16'h0000) begin
         n_errors++;
         $display("FAIL drain_empty_read: got %h expected 0000", d);
      end
      do_read(2'd2, d, e);
      n_checks++;
      if (d !== 16'h0000) begin
         n_errors++;
         $display("FAIL drain_count: got %h expected 0000", d);
      end
   endtask

   task automatic test_push_pop_same();
      logic [WIDTH-1:0] d, r, e;
      push_word(16'h0101);
      push_word(16'h0202);
      io_addr = 2'd0;
      io_rd   = 1'b1;
      tick();
      r         = bus;
      m_pop_due = 1'b1;
      io_rd     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h0303;
      tick();
      in_valid = 1'b0;
      tick();
      n_checks++;
      if (r !== 16'h0101) begin
         n_errors++;
         $display("FAIL pp_head: got %h expected 0101", r);
      end
      do_read(2'd2, d, e);
      n_checks++;
      if (d !== 16'h0002) begin
         n_errors++;
         $display("FAIL pp_count: got %h expected 0002", d);
      end
      do_read(2'd0, d, e);
      n_checks++;
      if (d !== 16'h0202) begin
         n_errors++;
         $display("FAIL pp_order1: got %h expected 0202", d);
      end
      do_read(2'd0, d, e);
      n_checks++;
      if (d !== 16'h0303) begin
         n_errors++;
         $display("FAIL pp_order2: got %h expected 0303", d);
      end
   endtask

   task automatic test_illegal();
      logic [WIDTH-1:0] d, e;
      push_word(16'h0777);
      io_addr   = 2'd0;
      io_rd     = 1'b1;
      io_wr     = 1'b1;
      tb_bus_en = 1'b1;
      tb_bus    = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (rdy !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_rdy: cycle %0d rdy=%b expected 0", i, rdy);
         end
      end
      io_rd     = 1'b0;
      io_wr     = 1'b0;
      tb_bus_en = 1'b0;
      tick();
      n_checks++;
      if (out_port !== m_out_port) begin
         n_errors++;
         $display("FAIL illegal_out_port: got %h expected %h", out_port, m_out_port);
      end
      do_read(2'd2, d, e);
      n_checks++;
      if (d !== 16'h0001) begin
         n_errors++;
         $display("FAIL illegal_count: got %h expected 0001", d);
      end
      do_read(2'd0, d, e);
      n_checks++;
      if (d !== 16'h0777) begin
         n_errors++;
         $display("FAIL illegal_data: got %h expected 0777", d);
      end
   endtask

`ifdef IO_BUS_RESPONDER_IRQ_EN
   task automatic test_irq();
      logic [WIDTH-1:0] d, e;
      do_write(2'd1, 16'h0004);
      push_word(16'h00AB);
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++;
         $display("FAIL irq_lag: irq=%b expected 0", irq);
      end
      tick();
      n_checks++;
      if (irq !== 1'b1) begin
         n_errors++;
         $display("FAIL irq_rise: irq=%b expected 1", irq);
      end
      do_read(2'd1, d, e);
      n_checks++;
      if (d !== 16'h0005) begin
         n_errors++;
         $display("FAIL irq_status: got %h expected 0005", d);
      end
      io_addr = 2'd0;
      io_rd   = 1'b1;
      tick();
      d         = bus;
      m_pop_due = 1'b1;
      io_rd     = 1'b0;
      tick();
      n_checks++;
      if (irq !== 1'b1 || d !== 16'h00AB) begin
         n_errors++;
         $display("FAIL irq_pop_edge: irq=%b data=%h expected 1/00ab", irq, d);
      end
      tick();
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++;
         $display("FAIL irq_fall: irq=%b expected 0", irq);
      end
      do_write(2'd1, 16'h0000);
   endtask
`endif

   task automatic test_random();
      logic [WIDTH-1:0] d, e, wd;
      logic [1:0]       a;
      m_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         a = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            wd = WIDTH'($urandom);
            do_write(a, wd);
         end else begin
            do_read(a, d, e);
            n_checks++;
            if (d !== e) begin
               n_errors++;
               $display("FAIL rand_read: iter %0d addr %0d got %h expected %h", i, a, d, e);
            end
         end
         n_checks++;
         if (in_ready !== (m_q.size() < DEPTH) || out_port !== m_out_port || irq !== m_irq) begin
            n_errors++;
            $display("FAIL rand_state: iter %0d in_ready=%b out_port=%h irq=%b expected %b/%h/%b",
                     i, in_ready, out_port, irq, (m_q.size() < DEPTH), m_out_port, m_irq);
         end
      end
      m_rand   = 1'b0;
      in_valid = 1'b0;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #22;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_write_data();
      test_fill_drain();
      test_push_pop_same();
      test_illegal();
`ifdef IO_BUS_RESPONDER_IRQ_EN
      test_irq();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/io_bus_responder.md
# io_bus_responder

Memory-mapped I/O peripheral that sits on the far side of the CPU's bidirectional 16-bit data bus and answers CPU read/write strobes. It latches CPU writes into an output port and buffers peripheral input words in a small FIFO. It drives the bus during reads with a registered handshake, and raises an optional data-available interrupt.

## Interface
- `WIDTH`, 16, data bus and port width
- `DEPTH`, 4, input FIFO depth in words (power of two, ≥2)
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `io_addr`  in  2  register select: 0 DATA, 1 STATUS, 2 COUNT, 3 reserved
- `io_rd`  in  1  CPU read strobe, level, held until `rdy` seen
- `io_wr`  in  1  CPU write strobe, level, held until `rdy` seen
- `bus`  inout  WIDTH  shared data bus; driven only in read ACCESS state, else `'z`
- `rdy`  out  1  transaction acknowledge
- `in_data`  in  WIDTH  peripheral word to enqueue
- `in_valid`  in  1  peripheral word valid
- `in_ready`  out  1  FIFO can accept (= not full)
- `out_port`  out  WIDTH  last word written to DATA
- `irq`  out  1  data-available interrupt

## Operation
- **Reset (async, `reset_n`=0).**
  - FSM=IDLE; FIFO empty, count 0.
  - `out_port`=0, `irq_en`=0, `rdy`=0, `irq`=0, `in_ready`=1, `bus`='z.
  - Reset mid-transaction aborts it; a pending pop is not performed.
- **FSM states: IDLE, ACCESS, DONE.**
  - IDLE→ACCESS when exactly one of `io_rd`/`io_wr` is high at a clock edge. The address is latched, and on reads the read word is registered at that same edge.
  - `io_rd`&`io_wr` both high: illegal. Stay IDLE, no `rdy`, no side effects.
  - ACCESS→DONE unconditionally after one cycle.
  - DONE→IDLE when `io_rd`=`io_wr`=0. Otherwise hold DONE; no repeat access.
- **Read data by address.**
  - DATA: FIFO head, or 0 if empty. Pop occurs at the ACCESS→DONE edge, only if the FIFO was non-empty.
  - STATUS: {zeros, bit2 `irq_en`, bit1 full, bit0 not-empty}.
  - COUNT: occupancy, zero-extended; range 0..DEPTH.
  - Reserved: 0.
- **Write effects by address.** The bus is sampled at the IDLE→ACCESS edge.
  - DATA: `out_port` ← bus.
  - STATUS: `irq_en` ← bus[2].
  - COUNT and reserved: ignored, but still acknowledged.
- **FIFO.**
  - Push when `in_valid`&`in_ready` at an edge. `in_ready`=!full, combinational from count.
  - Push and pop on the same edge: count unchanged, data order preserved.
  - When full, `in_ready`=0 even if a pop happens that edge; the freed slot is usable next cycle.
  - Read/write pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- **Interrupt.** `irq` = `irq_en` & not-empty, registered.

## Timing
- Strobe sampled high at edge N: `rdy`=1 and, on reads, `bus` driven for cycle N→N+1.
- At edge N+1: `rdy`=0, `bus` released, pop committed.
- Latency strobe→`rdy` is 1 cycle. `rdy` is a single-cycle pulse per transaction.
- Minimum transaction spacing is 3 cycles (IDLE, ACCESS, DONE with strobes already low).
- `irq` lags FIFO state by 1 cycle. A pop that empties the FIFO drops `irq` one cycle after the pop edge.

## Configuration
- `IO_BUS_RESPONDER_IRQ_EN` defined: `irq_en` register, STATUS bit2 and the registered `irq` are present as described above.
- Not defined:
  - `irq` tied to 0 and STATUS bit2 reads 0.
  - STATUS writes are acknowledged with no effect.
  - No `irq_en` flop is synthesized.

## Structure
- **Shared package:**
  - register address constants (DATA=0, STATUS=1, COUNT=2)
  - STATUS bit positions
  - FSM state enum typedef
- **Sub-module `io_fifo`:** sync FIFO with push/pop/full/empty/count and a combinational head output, parameterized by WIDTH and DEPTH.
- **Top level:** FSM, register file, tristate bus driver.

## Test plan
- Reset with `reset_n`=0 mid-read → `rdy`=0, `bus`=z, `out_port`=0, count 0, `irq`=0 immediately (asynchronous).
- Write 16'hA5C3 to DATA → `rdy` pulse 1 cycle after strobe; `out_port`=16'hA5C3; DONE held until `io_wr` drops.
- Push 0x0011, 0x0022, 0x0033, 0x0044 (DEPTH 4) → `in_ready`=0, STATUS reads 16'h0003, COUNT reads 4. A fifth `in_valid` is dropped.
- Four DATA reads → 0x0011..0x0044 in order. A fifth read returns 0 with count still 0.
- Push and DATA-read pop on the same edge with count 2 → count stays 2, read word is the old head.
- With the macro defined: write STATUS 16'h0004, then push one word → `irq`=1 one cycle later. A DATA read drops `irq` one cycle after the pop. `io_rd`&`io_wr` both high → no `rdy`, no state change.
